// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter that serialises register
// transactions from NUM_REQ requesters onto one I2C controller.
// Ports: clk, rst_n (sync, active-low); per-requester req, req_addr,
// req_reg, req_rw, req_len, req_wdata in; gnt, done, err, rdata out;
// ctl_en/addr/reg/rw/len/din to controller; ctl_busy/ctl_dout from it.
// Optional: define I2C_ARB_TIMEOUT_EN to abort phases stuck for
// TIMEOUT_CYCLES clocks (done + err pulse, rdata kept).
module i2c_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_reg,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [NUM_REQ-1:0]     req_len,
    input  logic [16*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic [15:0]            rdata,
    output logic                   ctl_en,
    output logic [6:0]             ctl_addr,
    output logic [7:0]             ctl_reg,
    output logic                   ctl_rw,
    output logic                   ctl_len,
    output logic [15:0]            ctl_din,
    input  logic                   ctl_busy,
    input  logic [15:0]            ctl_dout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [15:0]        rdata_q, rdata_d;
    logic [6:0]         addr_q, addr_d;
    logic [7:0]         reg_q, reg_d;
    logic               rw_q, rw_d;
    logic               len_q, len_d;
    logic [15:0]        din_q, din_d;

    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      cand;
    logic               tmo;

    // Search starts one past the last winner so every
    // requester is reached within NUM_REQ grants.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (int'(ptr_q) + k >= NUM_REQ) begin
                cand = IW'(int'(ptr_q) + k - NUM_REQ);
            end else begin
                cand = IW'(int'(ptr_q) + k);
            end
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        reg_d   = reg_q;
        rw_d    = rw_q;
        len_d   = len_q;
        din_d   = din_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    ptr_d          = win_idx;
                    addr_d  = req_addr[int'(win_idx)*7 +: 7];
                    reg_d   = req_reg[int'(win_idx)*8 +: 8];
                    rw_d    = req_rw[win_idx];
                    len_d   = req_len[win_idx];
                    din_d   = req_wdata[int'(win_idx)*16 +: 16];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (tmo) begin
                    done_d  = gnt_q;
                    state_d = DONE;
                end else if (ctl_busy) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tmo || !ctl_busy) begin
                    done_d  = gnt_q;
                    state_d = DONE;
                    // An aborted read must not clobber rdata.
                    if (!tmo && rw_q) begin
                        rdata_d = ctl_dout;
                    end
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NUM_REQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            reg_q   <= '0;
            rw_q    <= 1'b0;
            len_q   <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            rw_q    <= rw_d;
            len_q   <= len_d;
            din_q   <= din_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;
    logic          waiting;

    assign waiting = (state_q == LAUNCH) || (state_q == RUN);
    assign tmo = waiting && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Any state change restarts the count, so each phase
    // gets its own full budget.
    always_comb begin
        cnt_d = '0;
        if (waiting && (state_d == state_q)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= tmo;
        end
    end

    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign ctl_en   = (state_q == LAUNCH);
    assign ctl_addr = addr_q;
    assign ctl_reg  = reg_q;
    assign ctl_rw   = rw_q;
    assign ctl_len  = len_q;
    assign ctl_din  = din_q;

endmodule
